tdm_mux: RTL and testbench

- Parametrised, registered N:1 multiplexer; successor to the combinational 4:1 mux.
- Two modes:
  - Direct: channel chosen by a select input.
  - Scan: time-division round-robin with a programmable dwell per channel.
- Sits between parallel data sources and a single serial consumer; output tagged with channel index and a valid strobe.

---
 rtl/tdm_mux.sv | 176 +++++++++++++++++
 tb/tb_tdm_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux.sv
// tdm_mux: registered N:1 multiplexer with two modes. In direct mode a
// select input chooses the channel. In scan mode the channels are visited
// round-robin, and each one is presented for dwell+1 enabled cycles.
// All outputs are registered, with one cycle of latency.
// Optional build macro TDM_MUX_CH_MASK_EN adds a ch_mask input. The scan
// then skips masked channels, and direct mode rejects them.
module tdm_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL_W  = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [CHANNELS*WIDTH-1:0] din,
`ifdef TDM_MUX_CH_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      valid,
    output logic                      wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   NUM_CH  = (SEL_W + 1)'(CHANNELS);

    typedef enum logic {DIRECT, SCAN} state_t;

    state_t               state_reg, state_next;
    logic [SEL_W-1:0]     cur_reg, cur_next;
    logic [DWELL_W-1:0]   cnt_reg, cnt_next;
    logic                 pend_reg, pend_next;   // wrap owed on next presentation
    logic [WIDTH-1:0]     dout_reg, dout_next;
    logic [SEL_W-1:0]     ch_reg, ch_next;
    logic                 valid_reg, valid_next;
    logic                 wrap_reg, wrap_next;

    logic [CHANNELS-1:0]  mask_w;
    logic [WIDTH-1:0]     din_arr [CHANNELS];
    logic [SEL_W-1:0]     nxt_ch, low_ch, low_nxt;
    logic                 any_en, sel_ok;

`ifdef TDM_MUX_CH_MASK_EN
    assign mask_w = ch_mask;
`else
    assign mask_w = '1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign din_arr[gi] = din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The first enabled channel, searched circularly from c+1 (c itself last).
    // The caller detects a wrap as a result that is <= c.
    function automatic logic [SEL_W-1:0] next_of(input logic [SEL_W-1:0] c,
                                                 input logic [CHANNELS-1:0] m);
        logic [SEL_W-1:0] r;
        r = c;
        for (int i = CHANNELS; i >= 1; i--) begin
            int               j;
            logic [SEL_W-1:0] jj;
            j = int'(c) + i;
            if (j >= CHANNELS) j = j - CHANNELS;
            jj = SEL_W'(j);
            if (m[jj]) r = jj;
        end
        return r;
    endfunction

    assign any_en  = |mask_w;
    assign nxt_ch  = next_of(cur_reg, mask_w);
    assign low_ch  = next_of(LAST_CH, mask_w);
    assign low_nxt = next_of(low_ch, mask_w);
    assign sel_ok  = ({1'b0, sel} < NUM_CH) && mask_w[sel];

    // Next-state and output decode; en=0 holds everything but the strobes.
    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        dout_next  = dout_reg;
        ch_next    = ch_reg;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        if (en) begin
            if (!mode) begin
                state_next = DIRECT;
                cur_next   = '0;
                cnt_next   = '0;
                pend_next  = 1'b0;
                if (sel_ok) begin
                    dout_next  = din_arr[sel];
                    ch_next    = sel;
                    valid_next = 1'b1;
                end else begin
                    dout_next  = '0;
                end
            end else if (!any_en) begin
                // Nothing to scan: park with the scan position untouched.
                state_next = SCAN;
                dout_next  = '0;
            end else if (state_reg == DIRECT) begin
                // The entry cycle is the first dwell cycle of the lowest channel.
                state_next = SCAN;
                dout_next  = din_arr[low_ch];
                ch_next    = low_ch;
                valid_next = 1'b1;
                cnt_next   = DWELL_W'(1);
                if (dwell == '0) begin
                    cur_next  = low_nxt;
                    pend_next = (low_nxt <= low_ch);
                end else begin
                    cur_next  = low_ch;
                    pend_next = 1'b0;
                end
            end else if (!mask_w[cur_reg]) begin
                // Current channel was masked under us: skip it immediately.
                dout_next = '0;
                cur_next  = nxt_ch;
                cnt_next  = '0;
                pend_next = pend_reg | (nxt_ch <= cur_reg);
            end else begin
                dout_next  = din_arr[cur_reg];
                ch_next    = cur_reg;
                valid_next = 1'b1;
                wrap_next  = pend_reg;
                if (cnt_reg >= dwell) begin
                    cur_next  = nxt_ch;
                    cnt_next  = '0;
                    pend_next = (nxt_ch <= cur_reg);
                end else begin
                    cnt_next  = cnt_reg + 1'b1;
                    pend_next = 1'b0;
                end
            end
        end
    end

    // State and output registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DIRECT;
            cur_reg   <= '0;
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
            dout_reg  <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            dout_reg  <= dout_next;
            ch_reg    <= ch_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign dout   = dout_reg;
    assign ch_out = ch_reg;
    assign valid  = valid_reg;
    assign wrap   = wrap_reg;

endmodule

// File: tb/tb_tdm_mux.sv
// tb_tdm_mux: scoreboard bench for tdm_mux (3 channels of 4 bits).
// Each cycle of stimulus pushes an expected output, derived from a
// position-in-scan model. A monitor pops that value and compares it
// one clock later.
module tb_tdm_mux;

    localparam int W  = 4;
    localparam int CH = 3;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            en    = 1'b0;
    logic            mode  = 1'b0;
    logic [SW-1:0]   sel   = '0;
    logic [DW-1:0]   dwell = '0;
    logic [CH*W-1:0] din   = '0;
    logic [W-1:0]    dout;
    logic [SW-1:0]   ch_out;
    logic            valid;
    logic            wrap;

    tdm_mux #(.WIDTH(W), .CHANNELS(CH), .DWELL_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sel    (sel),
        .dwell  (dwell),
        .din    (din),
        .dout   (dout),
        .ch_out (ch_out),
        .valid  (valid),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] c;
        logic          v;
        logic          w;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the scan is described by the number of enabled cycles
    // since scan entry. The channel is (pos / (dwell+1)) mod CH.
    bit            m_scan = 1'b0;
    int            m_pos  = 0;
    logic [W-1:0]  m_dout = '0;
    logic [SW-1:0] m_ch   = '0;

    function automatic logic [W-1:0] chan(input logic [CH*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    task automatic drive(input bit e, input bit m, input int s, input int dw,
                         input logic [CH*W-1:0] dv);
        exp_t x;
        int   per;
        int   c;
        @(negedge clk);
        en = e; mode = m; sel = SW'(s); dwell = DW'(dw); din = dv;
        x.v = 1'b0;
        x.w = 1'b0;
        if (e) begin
            if (!m) begin
                m_scan = 1'b0;
                if (s < CH) begin
                    m_dout = chan(dv, s);
                    m_ch   = SW'(s);
                    x.v    = 1'b1;
                end else begin
                    m_dout = '0;
                end
            end else begin
                if (!m_scan) begin
                    m_scan = 1'b1;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
                per    = dw + 1;
                c      = (m_pos / per) % CH;
                m_dout = chan(dv, c);
                m_ch   = SW'(c);
                x.v    = 1'b1;
                x.w    = (m_pos > 0) && (m_pos % per == 0) && (c == 0);
            end
        end
        x.d = m_dout;
        x.c = m_ch;
        q.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({dout, ch_out, valid, wrap} !== 8'h00) begin
            errors++;
            $display("FAIL %s: got dout=%h ch=%0d valid=%b wrap=%b, want all 0",
                     tag, dout, ch_out, valid, wrap);
        end else begin
            $display("%s: outputs cleared", tag);
        end
    endtask

    // Monitor: compare each registered output against the scoreboard head.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (!rst && q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if ({dout, ch_out, valid, wrap} !== x) begin
                errors++;
                $display("FAIL out t=%0t: got dout=%h ch=%0d valid=%b wrap=%b, want dout=%h ch=%0d valid=%b wrap=%b",
                         $time, dout, ch_out, valid, wrap, x.d, x.c, x.v, x.w);
            end else begin
                $display("t=%0t dout=%h ch=%0d valid=%b wrap=%b", $time, dout, ch_out, valid, wrap);
            end
        end
    end

    initial begin
        logic [CH*W-1:0] dv;
        logic [31:0]     r;
        bit              cm;
        bit              e;
        int              dw;
        int              n;

        dv = 12'hCBA;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Direct mode: in-range selects, hold with en=0, out-of-range select.
        drive(1, 0, 2, 0, dv);
        drive(1, 0, 0, 0, dv);
        drive(0, 0, 2, 0, dv);
        drive(1, 0, 1, 0, dv);
        drive(1, 0, 3, 0, dv);
        drive(1, 0, 3, 0, dv);

        // Scan with dwell=1: 0,0,1,1,2,2,0(wrap),0,1.
        drive(1, 0, 0, 1, dv);
        for (int i = 0; i < 9; i++) drive(1, 1, 0, 1, dv);

        // Scan with dwell=0 and en toggling; din changes every cycle.
        drive(1, 0, 0, 0, dv);
        for (int i = 0; i < 10; i++) begin
            r = $urandom;
            drive(i % 3 != 1, 1, 0, 0, r[CH*W-1:0]);
        end

        // Async reset in mid-scan while channel 2 is presented.
        drive(1, 0, 0, 0, dv);
        n = 0;
        do begin
            drive(1, 1, 0, 0, dv);
            n++;
        end while (m_ch != 2 && n < 10);
        @(posedge clk);
        #2;
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        q.delete();
        m_scan = 1'b0;
        m_dout = '0;
        m_ch   = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, dv);

        // Random traffic. dwell changes only on enabled direct cycles.
        cm = 1'b0;
        dw = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) cm = ~cm;
            e = ($urandom_range(0, 4) != 0);
            if (!cm && e) dw = $urandom_range(0, 3);
            r = $urandom;
            drive(e, cm, $urandom_range(0, 3), dw, r[CH*W-1:0]);
        end

        drive(0, 0, 0, 0, dv);
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
